ram: RTL and testbench

- Byte-addressable, big-endian unified memory for the ARM32 processor.
- Two ports:
  - a read-only instruction fetch port;
  - a data port for byte, halfword and word loads and stores.
- Storage is a byte array named `mem`, indexed by byte address. Debug and preload paths may access it hierarchically.
- Sits beside the processor core; the core drives both ports from its fetch and memory-access stages.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_access_check.sv | 42 ++++
 rtl/ram.sv | 88 ++++++++
 tb/tb_ram.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory: access-size encoding and
// big-endian byte-lane placement.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned LANES = 4;

  // Bit offset within the right-aligned value of byte `lane` of an
  // access `nbytes` long; lane 0 (lowest address) is most significant.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane,
                                            input logic [2:0] nbytes);
    return 5'({2'(nbytes - 3'd1 - 3'(lane)), 3'b000});
  endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check for one memory access: alignment, size
// encoding and range, plus byte count and per-lane enables.
module mem_access_check
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        fault_c,
  output logic [2:0]  nbytes_c,
  output logic [3:0]  lane_en_c
);

  logic [32:0] last;
  logic        misaligned;

  always_comb begin
    nbytes_c   = '0;
    misaligned = 1'b0;
    lane_en_c  = '0;
    case (size)
      SZ_BYTE: nbytes_c = 3'd1;
      SZ_HALF: begin
        nbytes_c   = 3'd2;
        misaligned = addr[0];
      end
      SZ_WORD: begin
        nbytes_c   = 3'd4;
        misaligned = |addr[1:0];
      end
      default: misaligned = 1'b1;
    endcase
    // 33-bit sum so accesses near 2^32 fault instead of wrapping to low memory
    last    = {1'b0, addr} + 33'(nbytes_c) - 33'd1;
    fault_c = misaligned || (last >= 33'(DEPTH));
    for (int k = 0; k < int'(LANES); k++) begin
      lane_en_c[k] = (3'(k) < nbytes_c) && !fault_c;
    end
  end

endmodule

// File: rtl/ram.sv
// Byte-addressable big-endian unified memory with a read-only fetch port
// and a byte/halfword/word data port; one-cycle registered responses.
module ram
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];

  logic        i_fault;
  logic [2:0]  i_nbytes;
  logic [3:0]  i_lane;
  logic        d_fault;
  logic [2:0]  d_nbytes;
  logic [3:0]  d_lane;
  logic [31:0] i_word;
  logic [31:0] d_word;

  mem_access_check #(.DEPTH(DEPTH)) u_fetch_check (
    .addr     (i_addr),
    .size     (SZ_WORD),
    .fault_c  (i_fault),
    .nbytes_c (i_nbytes),
    .lane_en_c(i_lane)
  );

  mem_access_check #(.DEPTH(DEPTH)) u_data_check (
    .addr     (d_addr),
    .size     (d_size),
    .fault_c  (d_fault),
    .nbytes_c (d_nbytes),
    .lane_en_c(d_lane)
  );

  // Assemble right-aligned read data; disabled lanes (faults) read as zero.
  always_comb begin
    i_word = '0;
    d_word = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (i_lane[k])
        i_word = i_word | (32'(mem[AW'(i_addr + 32'(k))]) << lane_shift(2'(k), i_nbytes));
      if (d_lane[k])
        d_word = d_word | (32'(mem[AW'(d_addr + 32'(k))]) << lane_shift(2'(k), d_nbytes));
    end
  end

  // Response registers; reads sample pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata <= '0;
      i_err   <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else begin
      i_rdata <= i_word;
      i_err   <= i_fault;
      d_err   <= (d_re || d_we) && d_fault;
      if (d_re) d_rdata <= d_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && d_we && !d_fault) begin
      for (int k = 0; k < int'(LANES); k++) begin
        if (d_lane[k])
          mem[AW'(d_addr + 32'(k))] <= d_wdata[lane_shift(2'(k), d_nbytes) +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: a byte-array reference model predicts every
// cycle's outputs, a monitor compares them one cycle later.
module tb_ram;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_err;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_re;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_err;

  always #5 clk = ~clk;

  ram #(.DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk    (clk),
    .reset  (reset),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_err  (i_err),
    .d_addr (d_addr),
    .d_size (d_size),
    .d_re   (d_re),
    .d_we   (d_we),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_err  (d_err)
  );

  typedef struct {
    logic [31:0] i_rdata;
    logic        i_err;
    logic [31:0] d_rdata;
    logic        d_err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model[DEPTH];
  logic [31:0] held_rdata = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_fault(input logic [31:0] a, input int n);
    if (n == 0) return 1'b1;
    if ((a % 32'(n)) != 0) return 1'b1;
    return (longint'(a) + longint'(n) - 1) >= longint'(DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = (v << 8) | 32'(model[int'(a) + k]);
    return v;
  endfunction

  task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) model[int'(a) + k] = 8'(wd >> (8 * (n - 1 - k)));
  endtask

  // One request cycle: drive inputs, predict the response, update the model.
  task automatic issue(input logic rst, input logic [31:0] ia, input logic [31:0] da,
                       input logic [1:0] sz, input logic re, input logic we,
                       input logic [31:0] wd);
    exp_t e;
    int   n;
    bit   df;
    @(negedge clk);
    reset   = rst;
    i_addr  = ia;
    d_addr  = da;
    d_size  = sz;
    d_re    = re;
    d_we    = we;
    d_wdata = wd;
    cyc++;
    e.cyc = cyc;
    n  = nbytes_of(sz);
    df = model_fault(da, n);
    if (rst) begin
      held_rdata = '0;
      e.i_rdata  = '0;
      e.i_err    = 1'b0;
      e.d_err    = 1'b0;
    end else begin
      e.i_err   = model_fault(ia, 4);
      e.i_rdata = e.i_err ? 32'h0 : model_read(ia, 4);
      e.d_err   = (re || we) && df;
      if (re) held_rdata = df ? 32'h0 : model_read(da, n);
    end
    e.d_rdata = held_rdata;
    sb.push_back(e);
    if (!rst && we && !df) model_write(da, n, wd);
  endtask

  task automatic idle(input logic [31:0] ia);
    issue(1'b0, ia, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    issue(1'b0, 32'h0, a, sz, 1'b0, 1'b1, wd);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz);
    issue(1'b0, 32'h0, a, sz, 1'b1, 1'b0, 32'h0);
  endtask

  // Monitor: the response to each request is visible just after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("i_rdata@%0d", e.cyc), i_rdata, e.i_rdata);
        check($sformatf("i_err@%0d", e.cyc), 32'(i_err), 32'(e.i_err));
        check($sformatf("d_rdata@%0d", e.cyc), d_rdata, e.d_rdata);
        check($sformatf("d_err@%0d", e.cyc), 32'(d_err), 32'(e.d_err));
      end
    end
  end

  function automatic logic [31:0] rand_addr(input int n);
    logic [31:0] a;
    int          r = int'($urandom_range(0, 9));
    if (r == 0)      a = $urandom();
    else if (r == 1) a = 32'(DEPTH) - 32'd8 + $urandom_range(0, 15);
    else             a = $urandom_range(0, DEPTH - 1);
    if (r < 8 && n > 0) a = a & ~32'(n - 1);
    return a;
  endfunction

  initial begin
    int          w;
    logic [1:0]  sz;
    logic [31:0] ia;
    reset = 1'b1; i_addr = '0; d_addr = '0; d_size = '0;
    d_re = 1'b0; d_we = 1'b0; d_wdata = '0;

    issue(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
    issue(1'b1, 32'h4, 32'h0, 2'b10, 1'b1, 1'b0, 32'h0);

    // Give every byte a defined value.
    for (int a = 0; a < int'(DEPTH); a += 4) store(32'(a), 2'b10, 32'h0);

    // Word round-trip.
    store(32'h10, 2'b10, 32'h11223344);
    load(32'h10, 2'b10);
    check("mem[0x10]", 32'(dut.mem[16]), 32'h11);
    check("mem[0x13]", 32'(dut.mem[19]), 32'h44);

    // Sub-word store and loads.
    store(32'h21, 2'b00, 32'hFFFF_FFAB);
    load(32'h20, 2'b10);
    load(32'h20, 2'b01);
    load(32'h21, 2'b00);
    load(32'h22, 2'b01);

    // Instruction fetch, aligned and misaligned.
    store(32'h0, 2'b10, 32'hE3A00005);
    idle(32'h0);
    idle(32'h2);
    idle(32'(DEPTH) - 32'd4);
    idle(32'(DEPTH));

    // Faults.
    store(32'h3, 2'b10, 32'hCAFEBABE);
    load(32'(DEPTH) - 32'd2, 2'b10);
    check("mem[0x3] after faulting store", 32'(dut.mem[3]), 32'h05);
    check("mem[0x4] after faulting store", 32'(dut.mem[4]), 32'h00);
    issue(1'b0, 32'h0, 32'h8, 2'b11, 1'b1, 1'b0, 32'h0);
    issue(1'b0, 32'h0, 32'hFFFF_FFFE, 2'b01, 1'b0, 1'b1, 32'h1234);
    load(32'h21, 2'b01);

    // Read-first on both ports.
    store(32'h40, 2'b10, 32'hDEADBEEF);
    issue(1'b0, 32'h40, 32'h40, 2'b10, 1'b1, 1'b1, 32'h12345678);
    issue(1'b0, 32'h40, 32'h40, 2'b10, 1'b1, 1'b0, 32'h0);

    // Reset during a store.
    issue(1'b1, 32'h10, 32'h50, 2'b10, 1'b1, 1'b1, 32'h5555AAAA);
    load(32'h50, 2'b10);
    check("mem[0x50] after reset store", 32'(dut.mem[80]), 32'h00);
    load(32'h10, 2'b10);
    idle(32'h10);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ia = rand_addr(4);
      issue(($urandom_range(0, 49) == 0), ia, rand_addr(nbytes_of(sz)), sz,
            1'($urandom()), 1'($urandom()), $urandom());
    end

    idle(32'h0);
    w = 0;
    while (sb.size() != 0 && w < 10) begin
      @(posedge clk);
      #2;
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    for (int a = 0; a < int'(DEPTH); a++)
      check($sformatf("mem[%0d]", a), 32'(dut.mem[a]), 32'(model[a]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
